// File: rtl/fetch_res_queue.sv
// Fetch-result queue: slices an aligned fetch block into per-slot instructions,
// masks slots by PC offset and predicted-taken branch, and buffers packets for decode.
module fetch_res_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 4,
  parameter int XLEN        = 64,
  localparam int SW         = $clog2(FETCH_WIDTH),
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_i_valid,
  output logic                      io_o_ready,
  input  logic [XLEN-1:0]           io_i_pc,
  input  logic [32*FETCH_WIDTH-1:0] io_i_fetch_res,
  input  logic                      io_i_flush,
  input  logic                      io_i_bp_valid,
  input  logic                      io_i_bp_taken,
  input  logic [SW-1:0]             io_i_bp_select,
  input  logic [XLEN-1:0]           io_i_bp_target,
  input  logic [3:0]                io_i_bp_branch_type,
  input  logic                      io_i_presolve_valid,
  input  logic                      io_i_presolve_taken,
  output logic                      io_o_pack_valid,
  input  logic                      io_i_pack_ready,
  output logic [XLEN-1:0]           io_o_pack_pc,
  output logic [FETCH_WIDTH-1:0]    io_o_pack_valids,
  output logic [32*FETCH_WIDTH-1:0] io_o_pack_insts,
  output logic                      io_o_pack_bp_valid,
  output logic                      io_o_pack_bp_taken,
  output logic [SW-1:0]             io_o_pack_bp_select,
  output logic [XLEN-1:0]           io_o_pack_bp_target,
  output logic [3:0]                io_o_pack_bp_branch_type,
  output logic [CW-1:0]             io_o_count
);

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [FETCH_WIDTH-1:0]    valids;
    logic [32*FETCH_WIDTH-1:0] insts;
    logic                      bp_valid;
    logic                      bp_taken;
    logic [SW-1:0]             bp_select;
    logic [XLEN-1:0]           bp_target;
    logic [3:0]                bp_branch_type;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [AW-1:0]       head_q, head_d;
  logic [AW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ready_q, ready_d;

  logic [SW-1:0]          off;
  logic [FETCH_WIDTH-1:0] slot_valids;
  logic                   enq;
  logic                   deq;
  entry_t                 new_entry;
  entry_t                 head_entry;

  assign off = io_i_pc[SW+1:2];

  // Slots before the PC offset and after a predicted-taken branch are dead.
  always_comb begin
    slot_valids = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      slot_valids[k] = (SW'(k) >= off) &&
                       !(io_i_bp_valid && io_i_bp_taken && (SW'(k) > io_i_bp_select));
    end
  end

  // Killed or empty packets are dropped, not back-pressured.
  assign enq = io_i_valid && ready_q && !io_i_flush &&
               !(io_i_presolve_valid && io_i_presolve_taken) && (|slot_valids);
  assign deq = (count_q != '0) && io_i_pack_ready;

  always_comb begin
    new_entry                = '0;
    new_entry.pc             = {io_i_pc[XLEN-1:SW+2], {(SW+2){1'b0}}};
    new_entry.valids         = slot_valids;
    new_entry.insts          = io_i_fetch_res;
    new_entry.bp_valid       = io_i_bp_valid;
    new_entry.bp_taken       = io_i_bp_taken;
    new_entry.bp_select      = io_i_bp_select;
    new_entry.bp_target      = io_i_bp_target;
    new_entry.bp_branch_type = io_i_bp_branch_type;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (io_i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    ready_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // Storage is deliberately not reset; only pointers define validity.
  always_ff @(posedge clock) begin
    if (enq) mem_q[tail_q] <= new_entry;
  end

  assign head_entry               = mem_q[head_q];
  assign io_o_ready               = ready_q;
  assign io_o_count               = count_q;
  assign io_o_pack_valid          = (count_q != '0);
  assign io_o_pack_pc             = head_entry.pc;
  assign io_o_pack_valids         = head_entry.valids;
  assign io_o_pack_insts          = head_entry.insts;
  assign io_o_pack_bp_valid       = head_entry.bp_valid;
  assign io_o_pack_bp_taken       = head_entry.bp_taken;
  assign io_o_pack_bp_select      = head_entry.bp_select;
  assign io_o_pack_bp_target      = head_entry.bp_target;
  assign io_o_pack_bp_branch_type = head_entry.bp_branch_type;

endmodule
